// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin arbiter with bounded bursts, sharing one single-port RAM between two Avalon-MM masters
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic       last_owner, prev_xfer, rd_pend, rd_owner;
  logic [3:0] beat_cnt;
  logic       req0, req1, keep, sel1, gnt0, gnt1, acc, rd_acc;
  // arbitration state: burst length, last owner and the outstanding read
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_owner <= 1'b1;
      beat_cnt   <= 4'd0;
      prev_xfer  <= 1'b0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      prev_xfer <= acc;
      rd_pend   <= rd_acc;
      if (rd_acc) rd_owner <= gnt1;
      if (acc) last_owner <= gnt1;
      beat_cnt  <= !acc ? 4'd0 :
                   (prev_xfer && gnt1 == last_owner) ? beat_cnt + {3'd0, beat_cnt != 4'hf} : 4'd1;
    end
  // same-cycle grant; requests are masked while in reset so nothing reaches the RAM
  always_comb begin
    req0   = reset_n & (m0_read | m0_write);
    req1   = reset_n & (m1_read | m1_write);
    keep   = prev_xfer & (beat_cnt < 4'(MAX_BURST));
    sel1   = (req0 & req1) ? (keep ? last_owner : ~last_owner) : req1;
    gnt1   = req1 & sel1;
    gnt0   = req0 & ~sel1;
    acc    = gnt0 | gnt1;
    rd_acc = gnt1 ? (m1_read & ~m1_write) : (gnt0 & m0_read & ~m0_write);
  end
  // stalls, RAM mux from the granted port, and read return steering
  always_comb begin
    m0_waitrequest   = req0 & ~gnt0;
    m1_waitrequest   = req1 & ~gnt1;
    mem_chipselect   = acc;
    mem_write        = gnt1 ? m1_write : (gnt0 & m0_write);
    mem_address      = gnt1 ? m1_address : gnt0 ? m0_address : '0;
    mem_byteenable   = gnt1 ? m1_byteenable : gnt0 ? m0_byteenable : '0;
    mem_writedata    = gnt1 ? m1_writedata : gnt0 ? m0_writedata : '0;
    mem_clken        = reset_n;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = rd_pend & ~rd_owner;
    m1_readdatavalid = rd_pend & rd_owner;
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed vectors, corner sequences and randomized traffic against a history-based reference
module tb_onchip_mem_arbiter;
  localparam int AW = 14, DW = 32, MB = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic mem_chipselect, mem_write, mem_clken;
  logic [31:0] ram [16384];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // byte-enabled single-port RAM, registered read with one cycle of latency
  always @(posedge clk)
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else mem_readdata <= ram[mem_address];
    end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle_in;
    set0(1'b0, 1'b0, '0, '0, '0);
    set1(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_wait0"}, m0_waitrequest, 1'b0);
    chk1({tag, "_wait1"}, m1_waitrequest, 1'b0);
    chk1({tag, "_rdv0"}, m0_readdatavalid, 1'b0);
    chk1({tag, "_rdv1"}, m1_readdatavalid, 1'b0);
    chk1({tag, "_cs"}, mem_chipselect, 1'b0);
    chk1({tag, "_mwr"}, mem_write, 1'b0);
    chk1({tag, "_clken"}, mem_clken, 1'b0);
    chkw({tag, "_maddr"}, 32'(mem_address), 32'd0);
    chkw({tag, "_mbe"}, 32'(mem_byteenable), 32'd0);
    chkw({tag, "_mwdata"}, mem_writedata, 32'd0);
  endtask

  // reset with requests present; everything must stay quiet until release
  task automatic do_reset;
    reset_n = 1'b0;
    set0(1'b1, 1'b0, 14'h10, 4'hf, 32'h0);
    set1(1'b0, 1'b1, 14'h20, 4'hf, 32'h1234);
    settle;
    chk_quiet("reset");
    tick;
    reset_n = 1'b1;
    idle_in;
  endtask

  typedef struct {
    logic r0, w1;
    logic [AW-1:0] a0, ea;
    logic ew0, ew1, ev0;
  } vec_t;
  vec_t tbl[10];

  logic [31:0] ref_mem [int];
  int hist[$];

  initial begin
    int last, run, g, streak0, streak1, max_streak;
    logic r0, r1, st0, st1, pv0, pv1, wr;
    logic [31:0] pdata, old, d;
    logic [3:0] be;
    int a;
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    // m0 streams reads while m1 keeps one write pending until its turn
    for (int i = 0; i < 10; i++) begin
      tbl[i].r0  = 1'b1;
      tbl[i].w1  = (i <= 4);
      tbl[i].a0  = AW'(i < 5 ? i : i - 1);
      tbl[i].ew0 = (i == 4);
      tbl[i].ew1 = (i < 4);
      tbl[i].ev0 = (i >= 1 && i <= 4) || i >= 6;
      tbl[i].ea  = i < 4 ? AW'(i) : i == 4 ? 14'h100 : AW'(i - 1);
    end
    idle_in;
    do_reset;

    // single port write then read back
    set0(1'b0, 1'b1, 14'h10, 4'hf, 32'hDEADBEEF);
    settle;
    chk1("sp_wr_wait0", m0_waitrequest, 1'b0);
    chk1("sp_wr_cs", mem_chipselect, 1'b1);
    chk1("sp_wr_mwr", mem_write, 1'b1);
    chkw("sp_wr_maddr", 32'(mem_address), 32'h10);
    chkw("sp_wr_mbe", 32'(mem_byteenable), 32'hf);
    chkw("sp_wr_mwdata", mem_writedata, 32'hDEADBEEF);
    tick;
    set0(1'b1, 1'b0, 14'h10, 4'hf, 32'h0);
    settle;
    chk1("sp_rd_wait0", m0_waitrequest, 1'b0);
    chk1("sp_rd_mwr", mem_write, 1'b0);
    chk1("sp_rd_rdv0_early", m0_readdatavalid, 1'b0);
    tick;
    idle_in;
    settle;
    chk1("sp_rdv0", m0_readdatavalid, 1'b1);
    chkw("sp_rdata0", m0_readdata, 32'hDEADBEEF);
    chk1("sp_rdv1", m1_readdatavalid, 1'b0);
    chk1("sp_idle_cs", mem_chipselect, 1'b0);
    tick;

    // byte lanes
    set0(1'b0, 1'b1, 14'h20, 4'hf, 32'h11223344);
    tick;
    set0(1'b0, 1'b1, 14'h20, 4'h5, 32'hAABBCCDD);
    settle;
    chkw("bl_mbe", 32'(mem_byteenable), 32'h5);
    tick;
    set0(1'b1, 1'b0, 14'h20, 4'hf, 32'h0);
    tick;
    idle_in;
    settle;
    chk1("bl_rdv0", m0_readdatavalid, 1'b1);
    chkw("bl_rdata0", m0_readdata, 32'h11BB33DD);
    tick;

    // first contention after reset goes to m0, then m1
    do_reset;
    set0(1'b1, 1'b0, 14'h10, 4'hf, 32'h0);
    set1(1'b1, 1'b0, 14'h20, 4'hf, 32'h0);
    settle;
    chk1("fc_wait0", m0_waitrequest, 1'b0);
    chk1("fc_wait1", m1_waitrequest, 1'b1);
    chkw("fc_maddr", 32'(mem_address), 32'h10);
    tick;
    set0(1'b0, 1'b0, '0, '0, '0);
    settle;
    chk1("fc_wait1_b", m1_waitrequest, 1'b0);
    chk1("fc_rdv0", m0_readdatavalid, 1'b1);
    chk1("fc_rdv1_early", m1_readdatavalid, 1'b0);
    chkw("fc_rdata0", m0_readdata, 32'hDEADBEEF);
    tick;
    idle_in;
    settle;
    chk1("fc_rdv1", m1_readdatavalid, 1'b1);
    chk1("fc_rdv0_late", m0_readdatavalid, 1'b0);
    chkw("fc_rdata1", m1_readdata, 32'h11BB33DD);
    tick;

    // burst fairness table
    do_reset;
    for (int i = 0; i < 10; i++) begin
      set0(tbl[i].r0, 1'b0, tbl[i].a0, 4'hf, 32'h0);
      set1(1'b0, tbl[i].w1, 14'h100, 4'hf, 32'hCAFE0000);
      settle;
      chk1($sformatf("bf%0d_wait0", i), m0_waitrequest, tbl[i].ew0);
      chk1($sformatf("bf%0d_wait1", i), m1_waitrequest, tbl[i].ew1);
      chk1($sformatf("bf%0d_rdv0", i), m0_readdatavalid, tbl[i].ev0);
      chk1($sformatf("bf%0d_rdv1", i), m1_readdatavalid, 1'b0);
      chkw($sformatf("bf%0d_maddr", i), 32'(mem_address), 32'(tbl[i].ea));
      tick;
    end

    // idle gap: m1 alone, one idle cycle, then contention returns to m0
    set0(1'b0, 1'b0, '0, '0, '0);
    set1(1'b0, 1'b1, 14'h30, 4'hf, 32'h5555AAAA);
    settle;
    chk1("ig_wait1", m1_waitrequest, 1'b0);
    tick;
    idle_in;
    tick;
    set0(1'b1, 1'b0, 14'h10, 4'hf, 32'h0);
    set1(1'b1, 1'b0, 14'h20, 4'hf, 32'h0);
    settle;
    chk1("ig_wait0", m0_waitrequest, 1'b0);
    chk1("ig_wait1", m1_waitrequest, 1'b1);
    tick;
    set0(1'b0, 1'b0, '0, '0, '0);
    tick;
    idle_in;
    tick;

    // reset pulse while a read is outstanding
    set0(1'b1, 1'b0, 14'h10, 4'hf, 32'h0);
    settle;
    chk1("rm_wait0", m0_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle_in;
    settle;
    chk_quiet("rm_inreset");
    tick;
    reset_n = 1'b1;
    settle;
    chk1("rm_rdv0_after", m0_readdatavalid, 1'b0);
    chk1("rm_rdv1_after", m1_readdatavalid, 1'b0);
    tick;
    set0(1'b1, 1'b0, 14'h10, 4'hf, 32'h0);
    set1(1'b1, 1'b0, 14'h20, 4'hf, 32'h0);
    settle;
    chk1("rm_fc_wait0", m0_waitrequest, 1'b0);
    chk1("rm_fc_wait1", m1_waitrequest, 1'b1);
    tick;
    set0(1'b0, 1'b0, '0, '0, '0);
    settle;
    chk1("rm_rdv0", m0_readdatavalid, 1'b1);
    chkw("rm_rdata0", m0_readdata, 32'hDEADBEEF);
    tick;
    idle_in;
    tick;

    // randomized traffic against a history-based model
    do_reset;
    hist.delete();
    st0 = 1'b0; st1 = 1'b0; pv0 = 1'b0; pv1 = 1'b0; pdata = '0;
    streak0 = 0; streak1 = 0; max_streak = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!st0) begin
        int op = $urandom_range(0, 9);
        set0(op < 4 || op == 6, op >= 4 && op <= 6, AW'(14'h200 + $urandom_range(0, 15)),
             4'($urandom_range(1, 15)), $urandom);
      end
      if (!st1) begin
        int op = $urandom_range(0, 9);
        set1(op < 4 || op == 6, op >= 4 && op <= 6, AW'(14'h200 + $urandom_range(0, 15)),
             4'($urandom_range(1, 15)), $urandom);
      end
      settle;
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      last = 1;
      for (int k = hist.size() - 1; k >= 0; k--)
        if (hist[k] != -1) begin
          last = hist[k];
          break;
        end
      run = 0;
      for (int k = hist.size() - 1; k >= 0 && hist[k] != -1 && hist[k] == last; k--) run++;
      g = (r0 && r1) ? ((run > 0 && run < MB) ? last : 1 - last) : r0 ? 0 : r1 ? 1 : -1;
      chk1("rnd_wait0", m0_waitrequest, r0 && g != 0);
      chk1("rnd_wait1", m1_waitrequest, r1 && g != 1);
      chk1("rnd_cs", mem_chipselect, g >= 0);
      chk1("rnd_rdv0", m0_readdatavalid, pv0);
      chk1("rnd_rdv1", m1_readdatavalid, pv1);
      if (pv0) chkw("rnd_rdata0", m0_readdata, pdata);
      if (pv1) chkw("rnd_rdata1", m1_readdata, pdata);
      pv0 = 1'b0; pv1 = 1'b0;
      if (g >= 0) begin
        wr = g == 1 ? m1_write : m0_write;
        a  = int'(g == 1 ? m1_address : m0_address);
        be = g == 1 ? m1_byteenable : m0_byteenable;
        d  = g == 1 ? m1_writedata : m0_writedata;
        chk1("rnd_mwr", mem_write, wr);
        chkw("rnd_maddr", 32'(mem_address), 32'(a));
        if (wr) begin
          chkw("rnd_mbe", 32'(mem_byteenable), 32'(be));
          chkw("rnd_mwdata", mem_writedata, d);
          old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
          for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
          ref_mem[a] = old;
        end else begin
          pdata = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
          if (g == 1) pv1 = 1'b1; else pv0 = 1'b1;
        end
      end
      hist.push_back(g);
      st0 = r0 && g != 0;
      st1 = r1 && g != 1;
      streak0 = st0 ? streak0 + 1 : 0;
      streak1 = st1 ? streak1 + 1 : 0;
      if (streak0 > max_streak) max_streak = streak0;
      if (streak1 > max_streak) max_streak = streak1;
      tick;
    end
    idle_in;
    settle;
    chk1("rnd_rdv0_tail", m0_readdatavalid, pv0);
    chk1("rnd_rdv1_tail", m1_readdatavalid, pv1);
    chk1("rnd_max_wait", max_streak <= MB, 1'b1);
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
